// File: rtl/ysyx_25010008_lsu_if.sv
// Memory-side request/response bus between the LSU (master) and memory (slave).
// Request handshake is valid/ready; the response is a single valid pulse.
interface ysyx_25010008_lsu_if;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_resp_valid;
    logic [31:0] m_rdata;

    modport master (
        output m_req_valid, m_addr, m_wen, m_wdata, m_wstrb,
        input  m_req_ready, m_resp_valid, m_rdata
    );

    modport slave (
        input  m_req_valid, m_addr, m_wen, m_wdata, m_wstrb,
        output m_req_ready, m_resp_valid, m_rdata
    );
endinterface

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: IDLE/REQ/WAIT/RESP FSM with byte/half/word alignment.
// Define YSYX_25010008_MISALIGN_CHK_EN to trap misaligned half/word accesses.
module ysyx_25010008_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        suffix_b,
    input  logic        suffix_h,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    ysyx_25010008_lsu_if.master mem
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [1:0] SZ_W = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_B = 2'd2;

    logic [1:0]  state;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [1:0]  off;
    logic        mis;
    logic [31:0] rbuf;

    logic [1:0]  sz_in;
    logic [1:0]  off_in;
    logic [3:0]  strb_in;
    logic [31:0] wsh_in;
    logic        mis_in;
    logic [31:0] shr;
    logic [31:0] ld;

    assign busy = (state != IDLE);

    always_comb begin
        sz_in   = suffix_b ? SZ_B : (suffix_h ? SZ_H : SZ_W);
        off_in  = 2'b00;
        strb_in = 4'b1111;
        mis_in  = 1'b0;
        case (sz_in)
            SZ_B: begin
                off_in  = addr[1:0];
                strb_in = 4'b0001 << addr[1:0];
            end
            SZ_H: begin
                off_in  = {addr[1], 1'b0};
                strb_in = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
        if (!mem_wen) strb_in = 4'b0000;
        wsh_in = wdata << {off_in, 3'b000};
`ifdef YSYX_25010008_MISALIGN_CHK_EN
        case (sz_in)
            SZ_H:    mis_in = addr[0];
            SZ_W:    mis_in = |addr[1:0];
            default: mis_in = 1'b0;
        endcase
`endif
    end

    // Response word is realigned to bit 0, then truncated and extended.
    always_comb begin
        shr = rbuf >> {off, 3'b000};
        case (sz)
            SZ_B:    ld = {{24{sx & shr[7]}}, shr[7:0]};
            SZ_H:    ld = {{16{sx & shr[15]}}, shr[15:0]};
            default: ld = shr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            st              <= 1'b0;
            sz              <= SZ_W;
            sx              <= 1'b0;
            off             <= 2'b00;
            mis             <= 1'b0;
            rbuf            <= 32'h0;
            rdata           <= 32'h0;
            done            <= 1'b0;
            err             <= 1'b0;
            mem.m_req_valid <= 1'b0;
            mem.m_addr      <= 32'h0;
            mem.m_wen       <= 1'b0;
            mem.m_wdata     <= 32'h0;
            mem.m_wstrb     <= 4'b0000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_ren || mem_wen) begin
                        st  <= mem_wen;
                        sz  <= sz_in;
                        sx  <= sext;
                        off <= off_in;
                        mis <= mis_in;
                        if (mis_in) begin
                            state <= RESP;
                        end else begin
                            state           <= REQ;
                            mem.m_req_valid <= 1'b1;
                            mem.m_addr      <= {addr[31:2], 2'b00};
                            mem.m_wen       <= mem_wen;
                            mem.m_wdata     <= wsh_in;
                            mem.m_wstrb     <= strb_in;
                        end
                    end
                end
                REQ: begin
                    if (mem.m_req_ready) begin
                        mem.m_req_valid <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.m_resp_valid) begin
                        rbuf  <= mem.m_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    done  <= 1'b1;
                    err   <= mis;
                    state <= IDLE;
                    if (!st && !mis) rdata <= ld;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Directed self-checking bench for ysyx_25010008_lsu.
// Latency counts cycle 1 as the cycle right after the capture edge.
module tb_ysyx_25010008_lsu;
    logic        clk;
    logic        rst_n;
    logic        mem_ren;
    logic        mem_wen;
    logic        suffix_b;
    logic        suffix_h;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;

    ysyx_25010008_lsu_if mif();

    ysyx_25010008_lsu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .suffix_b (suffix_b),
        .suffix_h (suffix_h),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .mem      (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    int          r_lat;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic        r_wen;
    logic        r_stable;
    logic        r_saw_req;
    logic        r_busy_ok;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_done2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access and plays the memory; results land in r_* for checking.
    task automatic do_txn(input logic ren, input logic wen, input logic b,
                          input logic h, input logic sx, input logic [31:0] a,
                          input logic [31:0] wd, input int rdy_dly,
                          input int resp_dly, input logic [31:0] mrd);
        bit hs;
        bit hs_next;
        int rc;
        int wc;
        mem_ren = ren;
        mem_wen = wen;
        suffix_b = b;
        suffix_h = h;
        sext = sx;
        addr = a;
        wdata = wd;
        mif.m_rdata = mrd;
        step();
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        r_lat = 1;
        r_saw_req = 1'b0;
        r_stable = 1'b1;
        r_busy_ok = 1'b1;
        hs = 1'b0;
        rc = 0;
        wc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (!busy) r_busy_ok = 1'b0;
            hs_next = 1'b0;
            mif.m_req_ready = 1'b0;
            mif.m_resp_valid = 1'b0;
            if (mif.m_req_valid) begin
                if (!r_saw_req) begin
                    r_addr = mif.m_addr;
                    r_wdata = mif.m_wdata;
                    r_strb = mif.m_wstrb;
                    r_wen = mif.m_wen;
                end else if (mif.m_addr !== r_addr || mif.m_wdata !== r_wdata ||
                             mif.m_wstrb !== r_strb || mif.m_wen !== r_wen) begin
                    r_stable = 1'b0;
                end
                r_saw_req = 1'b1;
                if (rc >= rdy_dly) begin
                    mif.m_req_ready = 1'b1;
                    hs_next = 1'b1;
                end
                rc++;
            end else if (hs) begin
                if (wc >= resp_dly) mif.m_resp_valid = 1'b1;
                wc++;
            end
            step();
            if (hs_next) hs = 1'b1;
            r_lat++;
        end
        if (!done) r_lat = 99;
        mif.m_req_ready = 1'b0;
        mif.m_resp_valid = 1'b0;
        r_err = err;
        r_rdata = rdata;
        step();
        r_done2 = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({rdata, done, busy, err} !== 35'h0) begin
            $display("FAIL reset_core: got %h expected 0", {rdata, done, busy, err});
        end else pass_cnt++;
        total++;
        if ({mif.m_req_valid, mif.m_wen, mif.m_wstrb, mif.m_addr, mif.m_wdata} !== 70'h0) begin
            $display("FAIL reset_mem: got %h expected 0",
                     {mif.m_req_valid, mif.m_wen, mif.m_wstrb, mif.m_addr, mif.m_wdata});
        end else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lb();
        do_txn(1, 0, 1, 0, 1, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1234);
        total++;
        if (r_rdata !== 32'hFFFF_FF80) begin
            $display("FAIL lb_rdata: got %h expected %h", r_rdata, 32'hFFFF_FF80);
        end else pass_cnt++;
        total++;
        if (r_lat !== 4) begin
            $display("FAIL lb_latency: got %0d expected 4", r_lat);
        end else pass_cnt++;
        total++;
        if (r_addr !== 32'h8000_0000 || r_strb !== 4'b0000 || r_wen !== 1'b0) begin
            $display("FAIL lb_req: got addr %h strb %b wen %b expected 80000000 0000 0",
                     r_addr, r_strb, r_wen);
        end else pass_cnt++;
        total++;
        if (r_err !== 1'b0 || r_done2 !== 1'b0 || r_busy_ok !== 1'b1) begin
            $display("FAIL lb_flags: got err %b done2 %b busy_ok %b expected 0 0 1",
                     r_err, r_done2, r_busy_ok);
        end else pass_cnt++;
    endtask

    task automatic test_sh();
        do_txn(0, 1, 0, 1, 0, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h0);
        total++;
        if (r_strb !== 4'b1100 || r_wdata !== 32'hABCD_0000 ||
            r_addr !== 32'h8000_0000 || r_wen !== 1'b1) begin
            $display("FAIL sh_req: got strb %b wdata %h addr %h wen %b expected 1100 abcd0000 80000000 1",
                     r_strb, r_wdata, r_addr, r_wen);
        end else pass_cnt++;
        total++;
        if (r_rdata !== 32'hFFFF_FF80 || r_lat !== 4) begin
            $display("FAIL sh_done: got rdata %h lat %0d expected ffffff80 4", r_rdata, r_lat);
        end else pass_cnt++;
    endtask

    task automatic test_ready_stall();
        do_txn(1, 0, 0, 0, 0, 32'h8000_0004, 32'h0, 3, 0, 32'hDEAD_BEEF);
        total++;
        if (r_lat !== 7) begin
            $display("FAIL stall_latency: got %0d expected 7", r_lat);
        end else pass_cnt++;
        total++;
        if (r_stable !== 1'b1 || r_addr !== 32'h8000_0004 || r_busy_ok !== 1'b1) begin
            $display("FAIL stall_stable: got stable %b addr %h busy_ok %b expected 1 80000004 1",
                     r_stable, r_addr, r_busy_ok);
        end else pass_cnt++;
        total++;
        if (r_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL stall_rdata: got %h expected deadbeef", r_rdata);
        end else pass_cnt++;
    endtask

    task automatic test_both();
        do_txn(1, 1, 1, 0, 0, 32'h1000_0001, 32'h0000_0055, 0, 0, 32'h1234_5678);
        total++;
        if (r_wen !== 1'b1 || r_strb !== 4'b0010 || r_wdata !== 32'h0000_5500) begin
            $display("FAIL both_req: got wen %b strb %b wdata %h expected 1 0010 00005500",
                     r_wen, r_strb, r_wdata);
        end else pass_cnt++;
        total++;
        if (r_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL both_rdata: got %h expected deadbeef", r_rdata);
        end else pass_cnt++;
    endtask

    task automatic test_extend();
        do_txn(1, 0, 0, 1, 1, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_7FFF);
        total++;
        if (r_rdata !== 32'hFFFF_8001) begin
            $display("FAIL lh_rdata: got %h expected ffff8001", r_rdata);
        end else pass_cnt++;
        do_txn(1, 0, 0, 1, 0, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_7FFF);
        total++;
        if (r_rdata !== 32'h0000_8001) begin
            $display("FAIL lhu_rdata: got %h expected 00008001", r_rdata);
        end else pass_cnt++;
        do_txn(1, 0, 1, 0, 0, 32'h0000_0001, 32'h0, 0, 0, 32'h1234_80AB);
        total++;
        if (r_rdata !== 32'h0000_0080) begin
            $display("FAIL lbu_rdata: got %h expected 00000080", r_rdata);
        end else pass_cnt++;
        do_txn(1, 0, 0, 0, 1, 32'h0000_0008, 32'h0, 0, 0, 32'h8000_0000);
        total++;
        if (r_rdata !== 32'h8000_0000) begin
            $display("FAIL lw_sext_rdata: got %h expected 80000000", r_rdata);
        end else pass_cnt++;
    endtask

    task automatic test_resp_delay();
        do_txn(0, 1, 1, 0, 0, 32'h0000_0003, 32'h0000_00A5, 0, 2, 32'h0);
        total++;
        if (r_strb !== 4'b1000 || r_wdata !== 32'hA500_0000) begin
            $display("FAIL sb_req: got strb %b wdata %h expected 1000 a5000000", r_strb, r_wdata);
        end else pass_cnt++;
        total++;
        if (r_lat !== 6 || r_done2 !== 1'b0) begin
            $display("FAIL sb_latency: got lat %0d done2 %b expected 6 0", r_lat, r_done2);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_txn(1, 0, 1, 0, 1, 32'h0000_0000, 32'h0, 0, 0, 32'hFFFF_FF7F);
        total++;
        if (r_rdata !== 32'h0000_007F || r_lat !== 4) begin
            $display("FAIL b2b_first: got rdata %h lat %0d expected 0000007f 4", r_rdata, r_lat);
        end else pass_cnt++;
        do_txn(1, 0, 0, 1, 1, 32'h0000_0000, 32'h0, 0, 0, 32'h0000_F00D);
        total++;
        if (r_rdata !== 32'hFFFF_F00D || r_lat !== 4) begin
            $display("FAIL b2b_second: got rdata %h lat %0d expected fffff00d 4", r_rdata, r_lat);
        end else pass_cnt++;
    endtask

    task automatic test_misalign();
        do_txn(1, 0, 0, 0, 0, 32'h8000_0001, 32'h0, 0, 0, 32'hCAFE_F00D);
`ifdef YSYX_25010008_MISALIGN_CHK_EN
        total++;
        if (r_saw_req !== 1'b0 || r_lat !== 2) begin
            $display("FAIL mis_path: got req %b lat %0d expected 0 2", r_saw_req, r_lat);
        end else pass_cnt++;
        total++;
        if (r_err !== 1'b1 || r_rdata !== 32'hFFFF_F00D) begin
            $display("FAIL mis_result: got err %b rdata %h expected 1 fffff00d", r_err, r_rdata);
        end else pass_cnt++;
`else
        total++;
        if (r_saw_req !== 1'b1 || r_lat !== 4 || r_addr !== 32'h8000_0000) begin
            $display("FAIL mis_path: got req %b lat %0d addr %h expected 1 4 80000000",
                     r_saw_req, r_lat, r_addr);
        end else pass_cnt++;
        total++;
        if (r_err !== 1'b0 || r_rdata !== 32'hCAFE_F00D) begin
            $display("FAIL mis_result: got err %b rdata %h expected 0 cafef00d", r_err, r_rdata);
        end else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        mem_ren = 1'b1;
        suffix_b = 1'b0;
        suffix_h = 1'b0;
        sext = 1'b0;
        addr = 32'h0000_0010;
        step();
        mem_ren = 1'b0;
        mif.m_req_ready = 1'b1;
        step();
        mif.m_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        mif.m_rdata = 32'h1111_2222;
        mif.m_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        mif.m_resp_valid = 1'b0;
        total++;
        if (saw_done !== 1'b0) begin
            $display("FAIL rstmid_done: got %b expected 0", saw_done);
        end else pass_cnt++;
        total++;
        if ({rdata, done, busy, err, mif.m_req_valid, mif.m_wen,
             mif.m_wstrb, mif.m_addr, mif.m_wdata} !== 105'h0) begin
            $display("FAIL rstmid_outputs: got rdata %h busy %b req %b addr %h expected all 0",
                     rdata, busy, mif.m_req_valid, mif.m_addr);
        end else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        suffix_b = 1'b0;
        suffix_h = 1'b0;
        sext = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        mif.m_req_ready = 1'b0;
        mif.m_resp_valid = 1'b0;
        mif.m_rdata = 32'h0;
        test_reset();
        test_lb();
        test_sh();
        test_ready_stall();
        test_both();
        test_extend();
        test_resp_delay();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
